// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master among N_REQ requesters
module i2c_arbiter #(
    parameter int          N_REQ   = 4,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [7*N_REQ-1:0]    i_req_slave_address,
    input  logic [16*N_REQ-1:0]   i_req_register_address,
    input  logic [N_REQ-1:0]      i_req_is_read,
    input  logic [10*N_REQ-1:0]   i_req_nb_of_bytes,
    input  logic [8*N_REQ-1:0]    i_req_data_in,
    output logic [N_REQ-1:0]      o_grant,
    output logic [N_REQ-1:0]      o_done,
    output logic [15:0]           o_rd_data,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_m_start,
    output logic [6:0]            o_m_slave_address,
    output logic [15:0]           o_m_register_address,
    output logic                  o_m_is_read,
    output logic [9:0]            o_m_nb_of_bytes,
    output logic [7:0]            o_m_data_in,
    input  logic                  i_m_ready,
    input  logic [15:0]           i_m_data_out,
    input  logic                  i_m_error_out
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_last_grant;
    logic [IW-1:0]     r_owner;
    logic [N_REQ-1:0]  r_grant;
    logic [19:0]       r_timer;
    logic              r_timed_out;
    logic [15:0]       r_rd_data;
    logic [6:0]        r_m_slave_address;
    logic [15:0]       r_m_register_address;
    logic              r_m_is_read;
    logic [9:0]        r_m_nb_of_bytes;
    logic [7:0]        r_m_data_in;

    logic              w_hi_any;
    logic              w_lo_any;
    logic              w_any;
    logic [IW-1:0]     w_hi_idx;
    logic [IW-1:0]     w_lo_idx;
    logic [IW-1:0]     w_pick;
    logic [6:0]        w_sel_slave;
    logic [15:0]       w_sel_reg;
    logic              w_sel_rd;
    logic [9:0]        w_sel_nb;
    logic [7:0]        w_sel_din;
    logic              w_waiting;
    logic              w_timeout;

    // Round-robin pick: lowest requester above last_grant wins, else wrap to the lowest one at or below it
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                if (j > int'(r_last_grant)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = IW'(j);
                end else begin
                    w_lo_any = 1'b1;
                    w_lo_idx = IW'(j);
                end
            end
        end
    end

    assign w_any  = w_hi_any | w_lo_any;
    assign w_pick = w_hi_any ? w_hi_idx : w_lo_idx;

    // Mux the chosen requester's transaction fields out of the packed input buses
    always_comb begin
        w_sel_slave = '0;
        w_sel_reg   = '0;
        w_sel_rd    = 1'b0;
        w_sel_nb    = '0;
        w_sel_din   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_pick == IW'(j)) begin
                w_sel_slave = i_req_slave_address[j*7 +: 7];
                w_sel_reg   = i_req_register_address[j*16 +: 16];
                w_sel_rd    = i_req_is_read[j];
                w_sel_nb    = i_req_nb_of_bytes[j*10 +: 10];
                w_sel_din   = i_req_data_in[j*8 +: 8];
            end
        end
    end

    assign w_waiting = (r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE);
    // The abort fires on the edge where the counter reaches TIMEOUT
    assign w_timeout = w_waiting && (r_timer == (TIMEOUT - 20'd1));

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a timeout preempts any master handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (w_any) w_next = S_LAUNCH;
            S_LAUNCH:      w_next = S_WAIT_ACCEPT;
            S_WAIT_ACCEPT: begin
                if (w_timeout)       w_next = S_COMPLETE;
                else if (!i_m_ready) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_timeout)       w_next = S_COMPLETE;
                else if (i_m_ready)  w_next = S_COMPLETE;
            end
            S_COMPLETE:    w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    // Datapath: latch request on grant, run the timeout counter, capture read data, record owner
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_grant         <= IW'(N_REQ - 1);
            r_owner              <= '0;
            r_grant              <= '0;
            r_timer              <= '0;
            r_timed_out          <= 1'b0;
            r_rd_data            <= '0;
            r_m_slave_address    <= '0;
            r_m_register_address <= '0;
            r_m_is_read          <= 1'b0;
            r_m_nb_of_bytes      <= '0;
            r_m_data_in          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner              <= w_pick;
                        r_grant              <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_timer              <= '0;
                        r_timed_out          <= 1'b0;
                        r_m_slave_address    <= w_sel_slave;
                        r_m_register_address <= w_sel_reg;
                        r_m_is_read          <= w_sel_rd;
                        r_m_nb_of_bytes      <= w_sel_nb;
                        r_m_data_in          <= w_sel_din;
                    end
                end
                S_WAIT_ACCEPT, S_WAIT_DONE: begin
                    r_timer <= r_timer + 20'd1;
                    if (w_timeout) begin
                        r_timed_out <= 1'b1;
                        r_rd_data   <= '0;
                    end else if ((r_state == S_WAIT_DONE) && i_m_ready) begin
                        r_rd_data <= i_m_data_out;
                    end
                end
                S_COMPLETE: begin
                    r_grant      <= '0;
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign o_grant              = r_grant;
    assign o_done               = (r_state == S_COMPLETE) ? r_grant : '0;
    assign o_err                = (r_state == S_COMPLETE) && (r_timed_out || i_m_error_out);
    assign o_busy               = (r_state != S_IDLE);
    assign o_m_start            = (r_state == S_LAUNCH) || (r_state == S_WAIT_ACCEPT);
    assign o_rd_data            = r_rd_data;
    assign o_m_slave_address    = r_m_slave_address;
    assign o_m_register_address = r_m_register_address;
    assign o_m_is_read          = r_m_is_read;
    assign o_m_nb_of_bytes      = r_m_nb_of_bytes;
    assign o_m_data_in          = r_m_data_in;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - scoreboard bench for i2c_arbiter with a behavioural I2C master
module tb_i2c_arbiter;

    localparam int          N  = 4;
    localparam logic [19:0] TO = 20'd100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      i_req;
    logic [7*N-1:0]    i_req_slave_address;
    logic [16*N-1:0]   i_req_register_address;
    logic [N-1:0]      i_req_is_read;
    logic [10*N-1:0]   i_req_nb_of_bytes;
    logic [8*N-1:0]    i_req_data_in;
    logic [N-1:0]      o_grant;
    logic [N-1:0]      o_done;
    logic [15:0]       o_rd_data;
    logic              o_err;
    logic              o_busy;
    logic              m_start;
    logic [6:0]        o_m_slave_address;
    logic [15:0]       o_m_register_address;
    logic              o_m_is_read;
    logic [9:0]        o_m_nb_of_bytes;
    logic [7:0]        o_m_data_in;
    logic              m_ready    = 1'b1;
    logic [15:0]       m_data_out = '0;
    logic              m_error_out;

    always #5 clk = ~clk;

    i2c_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .i_clock                (clk),
        .i_reset_n              (rst_n),
        .i_req                  (i_req),
        .i_req_slave_address    (i_req_slave_address),
        .i_req_register_address (i_req_register_address),
        .i_req_is_read          (i_req_is_read),
        .i_req_nb_of_bytes      (i_req_nb_of_bytes),
        .i_req_data_in          (i_req_data_in),
        .o_grant                (o_grant),
        .o_done                 (o_done),
        .o_rd_data              (o_rd_data),
        .o_err                  (o_err),
        .o_busy                 (o_busy),
        .o_m_start              (m_start),
        .o_m_slave_address      (o_m_slave_address),
        .o_m_register_address   (o_m_register_address),
        .o_m_is_read            (o_m_is_read),
        .o_m_nb_of_bytes        (o_m_nb_of_bytes),
        .o_m_data_in            (o_m_data_in),
        .i_m_ready              (m_ready),
        .i_m_data_out           (m_data_out),
        .i_m_error_out          (m_error_out)
    );

    typedef struct {
        int          idx;
        logic [6:0]  slave;
        logic [15:0] regad;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          rem[N];
    logic [6:0]  sa_tab[N];
    logic [15:0] ra_tab[N];
    logic [15:0] mm_rdata = '0;
    int          mm_lat   = 50;
    bit          mm_dead  = 1'b0;
    int          mm_cnt   = 0;
    bit          mm_busy  = 1'b0;

    // Behavioural master: drops ready on start, raises it with data after mm_lat cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            mm_busy = 1'b0;
            m_ready = 1'b1;
        end else if (mm_dead) begin
            mm_busy = 1'b0;
            m_ready = 1'b0;
        end else if (!mm_busy) begin
            m_ready = 1'b1;
            if (m_start) begin
                mm_busy = 1'b1;
                m_ready = 1'b0;
                mm_cnt  = mm_lat;
            end
        end else begin
            mm_cnt = mm_cnt - 1;
            if (mm_cnt == 0) begin
                m_ready    = 1'b1;
                m_data_out = mm_rdata;
                mm_busy    = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at the falling edge, score any done pulse, release finished requesters
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("grant_onehot", 32'($countones(o_grant) <= 1), 1);
        if (o_done != '0) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(o_done), 0);
            end else begin
                e = sbq.pop_front();
                check("done_owner", 32'(o_done), 32'(1) << e.idx);
                check("done_grant", 32'(o_grant), 32'(o_done));
                check("rd_data", 32'(o_rd_data), 32'(e.rdata));
                check("err", 32'(o_err), 32'(e.err));
                check("m_slave", 32'(o_m_slave_address), 32'(e.slave));
                check("m_reg", 32'(o_m_register_address), 32'(e.regad));
            end
            for (int i = 0; i < N; i++) begin
                if (o_done[i]) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] <= 0) i_req[i] = 1'b0;
                end
            end
        end else begin
            check("err_without_done", 32'(o_err), 0);
        end
    endtask

    task automatic post(input int idx, input logic [6:0] sa, input logic [15:0] ra,
                        input bit rd, input logic [9:0] nb, input logic [7:0] d, input int count);
        i_req_slave_address[idx*7 +: 7]      = sa;
        i_req_register_address[idx*16 +: 16] = ra;
        i_req_is_read[idx]                   = rd;
        i_req_nb_of_bytes[idx*10 +: 10]      = nb;
        i_req_data_in[idx*8 +: 8]            = d;
        sa_tab[idx] = sa;
        ra_tab[idx] = ra;
        rem[idx]    = count;
        i_req[idx]  = 1'b1;
    endtask

    task automatic expect_done(input int idx, input logic [15:0] rdata, input logic err);
        exp_t e;
        e.idx   = idx;
        e.slave = sa_tab[idx];
        e.regad = ra_tab[idx];
        e.rdata = rdata;
        e.err   = err;
        sbq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || o_busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(n < budget), 1);
        sbq.delete();
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!m_start && n < budget) begin
            step();
            n++;
        end
        check("start_seen", 32'(m_start), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        step();
        while (o_done == '0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", 32'(o_done != '0), 1);
    endtask

    initial begin
        int c0;
        int hi;
        rst_n                  = 1'b0;
        i_req                  = '0;
        i_req_slave_address    = '0;
        i_req_register_address = '0;
        i_req_is_read          = '0;
        i_req_nb_of_bytes      = '0;
        i_req_data_in          = '0;
        m_error_out            = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; sa_tab[i] = '0; ra_tab[i] = '0;
        end

        // Reset values
        repeat (3) step();
        check("rst_grant", 32'(o_grant), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_m_start", 32'(m_start), 0);
        check("rst_m_slave", 32'(o_m_slave_address), 0);
        check("rst_m_reg", 32'(o_m_register_address), 0);
        check("rst_rd_data", 32'(o_rd_data), 0);
        rst_n = 1'b1;
        repeat (2) step();
        check("no_relaunch", 32'(o_busy), 0);

        // Contention: all four held, requester 0 asks twice; order 0,1,2,3,0
        mm_rdata = 16'h1234;
        post(0, 7'h10, 16'h1000, 1'b1, 10'd1, 8'h00, 2);
        post(1, 7'h11, 16'h1111, 1'b0, 10'd1, 8'h11, 1);
        post(2, 7'h12, 16'h2222, 1'b1, 10'd3, 8'h22, 1);
        post(3, 7'h13, 16'h3333, 1'b0, 10'd1, 8'h33, 1);
        expect_done(0, 16'h1234, 1'b0);
        expect_done(1, 16'h1234, 1'b0);
        expect_done(2, 16'h1234, 1'b0);
        expect_done(3, 16'h1234, 1'b0);
        expect_done(0, 16'h1234, 1'b0);
        drain(2000);

        // Single read on requester 2 with a field change during WAIT_DONE
        mm_rdata = 16'hEACC;
        post(2, 7'h29, 16'h0110, 1'b1, 10'd2, 8'h00, 1);
        expect_done(2, 16'hEACC, 1'b0);
        wait_start(10);
        check("rd_m_slave", 32'(o_m_slave_address), 32'h29);
        check("rd_m_reg", 32'(o_m_register_address), 32'h0110);
        check("rd_m_is_read", 32'(o_m_is_read), 1);
        check("rd_m_nb", 32'(o_m_nb_of_bytes), 2);
        check("rd_grant", 32'(o_grant), 32'h4);
        hi = 0;
        while (m_start && hi < 20) begin
            hi++;
            step();
        end
        check("m_start_cycles", 32'(hi), 2);
        check("m_ready_low_at_drop", 32'(m_ready), 0);
        repeat (5) step();
        i_req_register_address[2*16 +: 16] = 16'hBEEF;
        i_req_slave_address[2*7 +: 7]      = 7'h11;
        hi = 0;
        while (o_done == '0 && hi < 200) begin
            check("m_reg_stable", 32'(o_m_register_address), 32'h0110);
            step();
            hi++;
        end
        drain(100);

        // Timeout: master dead; last owner 2, so requester 3 times out, then 1 is served
        mm_dead  = 1'b1;
        mm_rdata = 16'h5A5A;
        post(1, 7'h21, 16'h0001, 1'b1, 10'd1, 8'h00, 1);
        post(3, 7'h23, 16'h0003, 1'b1, 10'd1, 8'h00, 1);
        expect_done(3, 16'h0000, 1'b1);
        expect_done(1, 16'h5A5A, 1'b0);
        wait_start(10);
        c0 = cyc;
        wait_done(300);
        check("timeout_cycles", 32'(cyc - c0), 101);
        check("timeout_m_start", 32'(m_start), 0);
        check("timeout_rd_zero", 32'(o_rd_data), 0);
        mm_dead = 1'b0;
        drain(500);

        // Master error flagged at completion
        mm_rdata    = 16'h7E57;
        m_error_out = 1'b1;
        post(0, 7'h30, 16'h0AAA, 1'b0, 10'd4, 8'h5C, 1);
        expect_done(0, 16'h7E57, 1'b1);
        drain(500);
        m_error_out = 1'b0;
        check("err_back_idle", 32'(o_busy), 0);

        // Back-to-back from one requester: one IDLE cycle between transactions
        mm_rdata = 16'hC0DE;
        mm_lat   = 3;
        post(3, 7'h33, 16'h4444, 1'b1, 10'd2, 8'h00, 2);
        expect_done(3, 16'hC0DE, 1'b0);
        expect_done(3, 16'hC0DE, 1'b0);
        wait_done(100);
        step();
        check("b2b_idle_gap", 32'(o_busy), 0);
        step();
        check("b2b_relaunch", 32'(o_grant), 32'h8);
        drain(200);
        mm_lat = 50;

        // Reset in WAIT_DONE, then requester 1 alone goes first
        post(2, 7'h29, 16'h0110, 1'b1, 10'd2, 8'h00, 1);
        wait_start(10);
        hi = 0;
        while (m_start && hi < 20) begin
            step();
            hi++;
        end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(o_grant), 0);
        check("arst_busy", 32'(o_busy), 0);
        check("arst_m_start", 32'(m_start), 0);
        i_req  = '0;
        rem[2] = 0;
        repeat (2) step();
        mm_rdata = 16'h0101;
        post(1, 7'h41, 16'h0505, 1'b1, 10'd1, 8'h00, 1);
        expect_done(1, 16'h0101, 1'b0);
        rst_n = 1'b1;
        drain(500);

        // After another reset, requester 0 wins when it is requesting
        rst_n = 1'b0;
        repeat (2) step();
        mm_rdata = 16'h0202;
        post(0, 7'h40, 16'h0606, 1'b1, 10'd1, 8'h00, 1);
        post(1, 7'h41, 16'h0707, 1'b1, 10'd1, 8'h00, 1);
        expect_done(0, 16'h0202, 1'b0);
        expect_done(1, 16'h0202, 1'b0);
        rst_n = 1'b1;
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
